// File: rtl/maze_pkg.sv
// Shared constants and encodings for the maze player controller.
// Optional step counter is enabled by MAZE_STEP_COUNT_EN (see maze_player_ctrl).
package maze_pkg;

    localparam int MAZE_DIM  = 15;
    localparam int CELL_BITS = 4;
    localparam int ROW_W     = MAZE_DIM * CELL_BITS;
    localparam int POS_W     = 4;

    localparam int WALL_N = 0;
    localparam int WALL_E = 1;
    localparam int WALL_S = 2;
    localparam int WALL_W = 3;

    localparam logic [POS_W-1:0] POS_MAX = POS_W'(MAZE_DIM - 1);

    localparam int STEP_W = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        CHK  = 2'd2,
        WIN  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    // Wall bit inside a cell that guards the given direction of travel.
    function automatic int dir_wall_bit(input dir_t d);
        case (d)
            DIR_UP:    return WALL_N;
            DIR_DOWN:  return WALL_S;
            DIR_LEFT:  return WALL_W;
            default:   return WALL_E;
        endcase
    endfunction

endpackage

// File: rtl/maze_wall_lookup.sv
// Combinational wall/edge check: selects the player's cell from a row word
// and reports whether the requested move is blocked.
module maze_wall_lookup
    import maze_pkg::*;
(
    input  logic [ROW_W-1:0] i_row_word,
    input  logic [POS_W-1:0] i_row,
    input  logic [POS_W-1:0] i_col,
    input  dir_t             i_dir,
    output logic             o_blocked
);

    logic [CELL_BITS-1:0] w_cell;
    logic                 w_wall;
    logic                 w_edge;

    // Explicit mux keeps the select in range even for an illegal column value.
    always_comb begin
        w_cell = '0;
        for (int c = 0; c < MAZE_DIM; c++) begin
            if (i_col == POS_W'(c)) begin
                w_cell = i_row_word[c*CELL_BITS +: CELL_BITS];
            end
        end
    end

    always_comb begin
        w_wall = w_cell[dir_wall_bit(i_dir)];
        w_edge = 1'b0;
        case (i_dir)
            DIR_UP:    w_edge = (i_row == '0);
            DIR_DOWN:  w_edge = (i_row == POS_MAX);
            DIR_LEFT:  w_edge = (i_col == '0);
            DIR_RIGHT: w_edge = (i_col == POS_MAX);
            default:   w_edge = 1'b1;
        endcase
    end

    assign o_blocked = w_wall | w_edge;

endmodule

// File: rtl/maze_player_ctrl.sv
// Player movement sequencer: button pulse -> row read -> wall check -> step.
// Define MAZE_STEP_COUNT_EN to add the step_count output.
module maze_player_ctrl
    import maze_pkg::*;
#(
    parameter int START_ROW = 0,
    parameter int START_COL = 0,
    parameter int GOAL_ROW  = 14,
    parameter int GOAL_COL  = 14
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic             btn_left,
    input  logic             btn_right,
    input  logic             restart,
    output logic             rd_en,
    output logic [POS_W-1:0] rd_row,
    input  logic [ROW_W-1:0] rd_data,
    output logic [POS_W-1:0] player_row,
    output logic [POS_W-1:0] player_col,
    output logic             busy,
    output logic             moved,
    output logic             blocked,
    output logic             won
`ifdef MAZE_STEP_COUNT_EN
    ,
    output logic [STEP_W-1:0] step_count
`endif
);

    localparam logic [POS_W-1:0] L_START_ROW = POS_W'(START_ROW);
    localparam logic [POS_W-1:0] L_START_COL = POS_W'(START_COL);
    localparam logic [POS_W-1:0] L_GOAL_ROW  = POS_W'(GOAL_ROW);
    localparam logic [POS_W-1:0] L_GOAL_COL  = POS_W'(GOAL_COL);

    state_t           r_state;
    dir_t             r_dir;
    logic [POS_W-1:0] r_row;
    logic [POS_W-1:0] r_col;
    logic             r_moved;
    logic             r_blocked;

    state_t           w_state_nxt;
    dir_t             w_dir_nxt;
    logic [POS_W-1:0] w_row_nxt;
    logic [POS_W-1:0] w_col_nxt;
    logic             w_moved_nxt;
    logic             w_blocked_nxt;
    logic             w_any_btn;
    logic             w_blocked_cond;

    assign w_any_btn = btn_up | btn_down | btn_left | btn_right;

    maze_wall_lookup u_wall_lookup (
        .i_row_word (rd_data),
        .i_row      (r_row),
        .i_col      (r_col),
        .i_dir      (r_dir),
        .o_blocked  (w_blocked_cond)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_dir     <= DIR_UP;
            r_row     <= L_START_ROW;
            r_col     <= L_START_COL;
            r_moved   <= 1'b0;
            r_blocked <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_dir     <= w_dir_nxt;
            r_row     <= w_row_nxt;
            r_col     <= w_col_nxt;
            r_moved   <= w_moved_nxt;
            r_blocked <= w_blocked_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_dir_nxt     = r_dir;
        w_row_nxt     = r_row;
        w_col_nxt     = r_col;
        w_moved_nxt   = 1'b0;
        w_blocked_nxt = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_any_btn) begin
                    w_state_nxt = RD;
                    if (btn_up)        w_dir_nxt = DIR_UP;
                    else if (btn_down) w_dir_nxt = DIR_DOWN;
                    else if (btn_left) w_dir_nxt = DIR_LEFT;
                    else               w_dir_nxt = DIR_RIGHT;
                end
            end
            RD: begin
                w_state_nxt = CHK;
            end
            CHK: begin
                if (w_blocked_cond) begin
                    w_blocked_nxt = 1'b1;
                end else begin
                    w_moved_nxt = 1'b1;
                    case (r_dir)
                        DIR_UP:    w_row_nxt = r_row - 1'b1;
                        DIR_DOWN:  w_row_nxt = r_row + 1'b1;
                        DIR_LEFT:  w_col_nxt = r_col - 1'b1;
                        default:   w_col_nxt = r_col + 1'b1;
                    endcase
                end
                if ((w_row_nxt == L_GOAL_ROW) && (w_col_nxt == L_GOAL_COL)) begin
                    w_state_nxt = WIN;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            WIN: begin
                w_state_nxt = WIN;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Restart aborts any move in flight, including its result pulse.
        if (restart) begin
            w_state_nxt   = IDLE;
            w_row_nxt     = L_START_ROW;
            w_col_nxt     = L_START_COL;
            w_moved_nxt   = 1'b0;
            w_blocked_nxt = 1'b0;
        end
    end

    assign rd_en      = (r_state == RD);
    assign rd_row     = rd_en ? r_row : '0;
    assign player_row = r_row;
    assign player_col = r_col;
    assign busy       = (r_state != IDLE);
    assign moved      = r_moved;
    assign blocked    = r_blocked;
    assign won        = (r_state == WIN);

`ifdef MAZE_STEP_COUNT_EN
    logic [STEP_W-1:0] r_steps;

    always_ff @(posedge clk) begin
        if (reset || restart) begin
            r_steps <= '0;
        end else if (w_moved_nxt && (r_state != WIN) && (r_steps != {STEP_W{1'b1}})) begin
            r_steps <= r_steps + 1'b1;
        end
    end

    assign step_count = r_steps;
`endif

endmodule
